multi_approach_signal_controller: RTL and testbench
===================================================

// Module: multi_approach_signal_controller
// PURPOSE
//  Parametrised successor of the two-road highway/country light controller.
//  Drives NUM_DIR approaches at one intersection, one green approach at a time.
//  Vehicle sensors are latched as pending requests and served round-robin.
//  Features: min/max green with extension, programmable yellow and all-red
//  clearance, and a rest approach that holds green when no traffic is present.
//  Sits between the sensor front-end and the lamp drivers.
// PARAMETERS
//  NUM_DIR    2   number of approaches (2..8); index 0 = main road
//  MIN_GREEN  4   minimum green length in cycles (>=1)
//  MAX_GREEN  12  maximum green length when extended (>=MIN_GREEN)
//  YELLOW_T   3   yellow length in cycles (>=1)
//  ALLRED_T   1   all-red clearance in cycles (0 = phase skipped)
//  REST_DIR   0   approach that takes green when no requests pend (<NUM_DIR)
// PORTS
//  clk        in   1                  system clock, rising edge
//  reset      in   1                  synchronous, active-high
//  sensor     in   NUM_DIR            vehicle present per approach, level
//  red        out  NUM_DIR            red lamp per approach
//  yellow     out  NUM_DIR            yellow lamp per approach
//  green      out  NUM_DIR            green lamp per approach
//  cur_dir    out  clog2(NUM_DIR)     approach currently owning green/yellow
//  phase      out  2                  0 = GREEN, 1 = YELLOW, 2 = ALLRED
//  pending    out  NUM_DIR            latched request vector
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: phase=GREEN, cur_dir=0, timer=0, pending=0, green=1<<0,
//    yellow=0, red=~(1<<0).
//  - Lamp rules, per approach i:
//    - exactly one of red/yellow/green is high
//    - i!=cur_dir: always red
//    - ALLRED: every approach red
//  - timer clears on every phase entry and increments each cycle in the phase.
//    Its width covers max(MAX_GREEN, YELLOW_T, ALLRED_T).
//  - pending[i]:
//    - set when sensor[i]=1, except while i owns GREEN
//    - cleared on the cycle i enters GREEN; a clear on the same cycle as a set wins
//  - other_req = |pending with bit cur_dir masked.
//  - GREEN exit is evaluated at the end of each cycle, with g = timer+1
//    (cycles of green elapsed):
//    - g < MIN_GREEN: stay.
//    - other_req=1: exit if sensor[cur_dir]=0 (gap-out), or if g >= MAX_GREEN
//      (max-out). Otherwise stay (extension).
//    - other_req=0 and cur_dir!=REST_DIR: exit with next=REST_DIR.
//    - other_req=0 and cur_dir==REST_DIR: stay indefinitely (rest in green).
//  - next approach on exit: first pending index searching cur_dir+1, +2, ...
//    modulo NUM_DIR (wrap-around). It is latched in nxt_dir at the exit
//    decision and does not change during YELLOW or ALLRED.
//  - YELLOW: exactly YELLOW_T cycles on cur_dir, then ALLRED.
//    If ALLRED_T=0, go straight to GREEN.
//  - ALLRED: exactly ALLRED_T cycles, then GREEN with cur_dir<=nxt_dir.
//  - Requests arriving during YELLOW or ALLRED only set pending.
//    They never change nxt_dir.
//  - Reset asserted in any phase: outputs take reset values on the next edge.
//    Lamps are not sequenced through yellow.
//  - No combinational path from sensor to any output.
// TESTING
//  1. reset high 2 cycles, sensor=0 -> green=01, red=10, phase=0, cur_dir=0.
//     Hold 50 cycles: unchanged (rest).
//  2. Defaults, sensor[1] 1-cycle pulse at cycle 10 with sensor[0]=0
//     -> pending=10, then:
//     - 3 cycles yellow=01
//     - 1 cycle red=11
//     - green=10 for 4 cycles
//     - yellow 3 cycles, all-red 1 cycle
//     - green=01 again
//  3. sensor[0]=1 held, sensor[1] pulse -> dir0 green lasts exactly
//     MAX_GREEN=12 cycles, then yellow.
//  4. NUM_DIR=4, cur_dir=2 green, pending=1010 -> serve order 3 then 1
//     (wrap), then back to REST_DIR 0.
//  5. reset pulsed during YELLOW of dir1 -> next cycle green=01, pending=0,
//     phase=0.
//  6. ALLRED_T=0 -> YELLOW goes directly to GREEN of nxt_dir; phase never
//     equals 2.

Source files
------------

// File: rtl/multi_approach_signal_controller.sv
// multi_approach_signal_controller: round-robin NUM_DIR-approach signal controller with
// min/max green, yellow and all-red clearance, and a rest approach.
module multi_approach_signal_controller #(
  parameter int NUM_DIR = 2,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int REST_DIR = 0,
  localparam int DW = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DIR-1:0] sensor,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DW-1:0]      cur_dir,
  output logic [1:0]         phase,
  output logic [NUM_DIR-1:0] pending
);
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} phase_t;
  localparam int TMAX = (MAX_GREEN > YELLOW_T) ? ((MAX_GREEN > ALLRED_T) ? MAX_GREEN : ALLRED_T)
                                               : ((YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [NUM_DIR-1:0] ONE = 1;
  phase_t st, ns;
  logic [TW-1:0] timer, tn;
  logic [TW:0] g;
  logic [DW-1:0] nxt_dir, nd, nn, cand;
  logic [NUM_DIR-1:0] other, own, pn, gn, yn;
  logic other_req, enter;
  assign phase = st;
  always_comb begin
    other = pending & ~(ONE << cur_dir);
    other_req = |other;
    g = {1'b0, timer} + 1'b1;
    cand = DW'(REST_DIR);
    // descending scan so the nearest pending approach after cur_dir wins
    for (int k = NUM_DIR - 1; k >= 1; k--)
      if (pending[(int'(cur_dir) + k) % NUM_DIR]) cand = DW'((int'(cur_dir) + k) % NUM_DIR);
    ns = st;
    nd = cur_dir;
    nn = nxt_dir;
    tn = (timer == TW'(TMAX)) ? timer : timer + 1'b1;
    case (st)
      GREEN:
        if (g >= (TW+1)'(MIN_GREEN) &&
            (other_req ? (!sensor[cur_dir] || g >= (TW+1)'(MAX_GREEN)) : cur_dir != DW'(REST_DIR))) begin
          ns = YELLOW;
          nn = other_req ? cand : DW'(REST_DIR);
          tn = '0;
        end
      YELLOW:
        if (g >= (TW+1)'(YELLOW_T)) begin
          ns = (ALLRED_T == 0) ? GREEN : ALLRED;
          nd = (ALLRED_T == 0) ? nxt_dir : cur_dir;
          tn = '0;
        end
      default:
        if (g >= (TW+1)'(ALLRED_T)) begin
          ns = GREEN;
          nd = nxt_dir;
          tn = '0;
        end
    endcase
    enter = ns == GREEN && st != GREEN;
    own = (st == GREEN) ? ONE << cur_dir : '0;
    pn = (pending | (sensor & ~own)) & ~(enter ? ONE << nd : '0);
    gn = (ns == GREEN) ? ONE << nd : '0;
    yn = (ns == YELLOW) ? ONE << nd : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= GREEN;
      cur_dir <= '0;
      nxt_dir <= '0;
      timer <= '0;
      pending <= '0;
      green <= ONE;
      yellow <= '0;
      red <= ~ONE;
    end else begin
      st <= ns;
      cur_dir <= nd;
      nxt_dir <= nn;
      timer <= tn;
      pending <= pn;
      green <= gn;
      yellow <= yn;
      red <= ~(gn | yn);
    end
  end
endmodule

// File: tb/tb_multi_approach_signal_controller.sv
// tb_multi_approach_signal_controller: directed vectors plus corner-case sequences
// on default, 4-approach and no-all-red instances.
module tb_multi_approach_signal_controller;
  logic clk = 0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic rst_a = 1, rst_b = 1, rst_c = 1;
  logic [1:0] s_a = 0, r_a, y_a, g_a, ph_a, pd_a, s_c = 0, r_c, y_c, g_c, ph_c, pd_c;
  logic cd_a, cd_c;
  logic [3:0] s_b = 0, r_b, y_b, g_b, pd_b;
  logic [1:0] ph_b, cd_b;
  logic saw_allred = 0;
  multi_approach_signal_controller dut_a (.clk(clk), .reset(rst_a), .sensor(s_a), .red(r_a),
    .yellow(y_a), .green(g_a), .cur_dir(cd_a), .phase(ph_a), .pending(pd_a));
  multi_approach_signal_controller #(.NUM_DIR(4)) dut_b (.clk(clk), .reset(rst_b), .sensor(s_b),
    .red(r_b), .yellow(y_b), .green(g_b), .cur_dir(cd_b), .phase(ph_b), .pending(pd_b));
  multi_approach_signal_controller #(.ALLRED_T(0)) dut_c (.clk(clk), .reset(rst_c), .sensor(s_c),
    .red(r_c), .yellow(y_c), .green(g_c), .cur_dir(cd_c), .phase(ph_c), .pending(pd_c));
  always @(negedge clk) if (!rst_c && ph_c == 2'd2) saw_allred <= 1;
  typedef struct packed {
    logic rst;
    logic [1:0] s;
    logic [10:0] exp;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic rst, input logic [1:0] s, g, y, r, ph, input logic cd,
                     input logic [1:0] pd, input int n = 1);
    repeat (n) tv.push_back('{rst, s, {g, y, r, ph, cd, pd}});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cnt, idx;
    logic [1:0] prev;
    logic [1:0] order[3];
    logic found;
    // rest after idle: green 01 / red 10 then 2-dir service cycle
    add(0, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0, 2'b10);
    add(0, 2'b00, 2'b00, 2'b01, 2'b10, 1, 0, 2'b10, 3);
    add(0, 2'b00, 2'b00, 2'b00, 2'b11, 2, 0, 2'b10);
    add(0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 2'b00, 4);
    add(0, 2'b00, 2'b00, 2'b10, 2'b01, 1, 1, 2'b00, 3);
    add(0, 2'b00, 2'b00, 2'b00, 2'b11, 2, 1, 2'b00);
    add(0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2);
    // request during min green, then reset in dir1 yellow
    add(0, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0, 2'b10);
    add(0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 0, 2'b10);
    add(0, 2'b00, 2'b00, 2'b01, 2'b10, 1, 0, 2'b10, 3);
    add(0, 2'b00, 2'b00, 2'b00, 2'b11, 2, 0, 2'b10);
    add(0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 2'b00, 4);
    add(0, 2'b00, 2'b00, 2'b10, 2'b01, 1, 1, 2'b00);
    add(1, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00);
    add(0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00);
    step();
    step();
    rst_a = 0; rst_b = 0; rst_c = 0;
    chk("reset_state", {g_a, y_a, r_a, ph_a, cd_a, pd_a}, {2'b01, 2'b00, 2'b10, 2'd0, 1'b0, 2'b00});
    repeat (50) step();
    chk("rest_hold", {g_a, y_a, r_a, ph_a, cd_a, pd_a}, {2'b01, 2'b00, 2'b10, 2'd0, 1'b0, 2'b00});
    foreach (tv[i]) begin
      rst_a = tv[i].rst;
      s_a = tv[i].s;
      step();
      chk($sformatf("vec%0d", i), {g_a, y_a, r_a, ph_a, cd_a, pd_a}, tv[i].exp);
    end
    rst_a = 0;
    s_a = 0;
    // max-out: dir0 extended while its sensor holds
    rst_a = 1;
    step();
    step();
    rst_a = 0;
    cnt = (ph_a == 2'd0) ? 1 : 0;
    s_a = 2'b11;
    for (int i = 0; i < 40; i++) begin
      step();
      s_a = 2'b01;
      if (ph_a != 2'd0) break;
      cnt++;
    end
    s_a = 0;
    chk("maxout_len", cnt, 12);
    chk("maxout_yellow", {ph_a, y_a}, {2'd1, 2'b01});
    // 4 approaches: wrap-around service order
    rst_b = 1;
    step();
    rst_b = 0;
    s_b = 4'b0100;
    step();
    s_b = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (ph_b == 2'd0 && cd_b == 2'd2);
    end
    chk("dir2_green", found, 1);
    s_b = 4'b1010;
    step();
    s_b = 0;
    chk("dir2_pending", pd_b, 4'b1010);
    chk("dir2_lamps", {g_b, r_b}, {4'b0100, 4'b1011});
    prev = 2'd2;
    idx = 0;
    order = '{default: 2'd2};
    for (int i = 0; i < 80 && idx < 3; i++) begin
      step();
      if (ph_b == 2'd0 && cd_b != prev) begin
        order[idx] = cd_b;
        prev = cd_b;
        idx++;
      end
    end
    chk("order0", order[0], 3);
    chk("order1", order[1], 1);
    chk("order2", order[2], 0);
    // no all-red clearance: yellow straight into green
    rst_c = 1;
    step();
    rst_c = 0;
    s_c = 2'b10;
    step();
    s_c = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = (ph_c == 2'd1);
    end
    chk("c_yellow_seen", found, 1);
    cnt = 0;
    while (ph_c == 2'd1 && cnt < 10) begin
      cnt++;
      step();
    end
    chk("c_yellow_len", cnt, 3);
    chk("c_green1", {ph_c, cd_c, g_c, r_c}, {2'd0, 1'b1, 2'b10, 2'b01});
    repeat (20) step();
    chk("c_back_rest", {ph_c, cd_c, g_c}, {2'd0, 1'b0, 2'b01});
    chk("c_no_allred", saw_allred, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
